// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit sampling and stop-bit checking.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int STOP_CHECK   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_error,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t          r_state, w_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [2:0]      r_idx, w_idx;
  logic [7:0]      r_shift, w_shift, r_data, w_data;
  logic            r_ready, w_ready, r_ferr, w_ferr;
  logic            w_rx_s;
  assign w_rx_s      = r_sync[1];
  assign rx_data     = r_data;
  assign rx_ready    = r_ready;
  assign frame_error = r_ferr;
  assign busy        = r_state != IDLE;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_data  = r_data;
    w_ready = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt   = '0;
        w_idx   = '0;
        w_state = w_rx_s ? IDLE : START;
      end
      START: if (r_cnt == HALF) begin
        w_cnt   = '0;
        w_state = w_rx_s ? IDLE : DATA;
      end
      DATA: if (r_cnt == FULL) begin
        w_cnt          = '0;
        w_shift[r_idx] = w_rx_s;
        w_idx          = r_idx + 1'b1;
        w_state        = (r_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (r_cnt == FULL) begin
        w_cnt = '0;
        if (w_rx_s || STOP_CHECK == 0) begin
          w_data  = r_shift;
          w_ready = 1'b1;
          w_state = IDLE;
        end else begin
          w_ferr  = 1'b1;
          w_state = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        w_cnt   = '0;
        w_state = w_rx_s ? IDLE : WAIT_HIGH;
      end
      default: begin
        w_cnt   = '0;
        w_state = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_ready <= w_ready;
      r_ferr  <= w_ferr;
    end
  end
endmodule
